safety_island_timer_unit: RTL

- Single 32-bit timer with prescaler, compare and overflow events. Sits on the core-local register bus at the timer output (TimerAddrOffset window, 0x8000).
- Produces the two timer interrupts per timer (NumTimerInterrupts = 2×NumTimers, with NumTimers = 1).
- Interrupt lines feed the CLIC ahead of the NumLocalInterrupts external lines.

---
 rtl/safety_island_timer_unit.sv | 86 ++++++++
 1 files changed

// File: rtl/safety_island_timer_unit.sv
// safety_island_timer_unit: 32-bit prescaled timer with compare/overflow interrupts on a zero-wait regbus.
// Register map: CTRL, COUNT, CMP, STATUS (W1C), IRQEN at word offsets 0x00..0x10.
module safety_island_timer_unit #(
    parameter int CntWidth   = 32,
    parameter int PrescWidth = 8,
    parameter int AddrWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 reg_valid_i,
    input  logic                 reg_write_i,
    input  logic [AddrWidth-1:0] reg_addr_i,
    input  logic [31:0]          reg_wdata_i,
    input  logic [3:0]           reg_wstrb_i,
    output logic                 reg_ready_o,
    output logic [31:0]          reg_rdata_o,
    output logic                 reg_error_o,
    output logic [1:0]           irq_o
);
    logic                  r_en, r_ac, r_os;
    logic [PrescWidth-1:0] r_presc, r_pcnt;
    logic [CntWidth-1:0]   r_cnt, r_cmp;
    logic [1:0]            r_st, r_ie;
    logic [2:0]            w_idx;
    logic                  w_err, w_we, w_tick, w_cnt_wr, w_ev, w_match, w_max, w_unused;
    logic [4:0]            w_wr;
    logic [31:0]           w_rsel, w_bmask, w_wval;
    logic [1:0]            w_set;

    assign w_unused = ^{reg_addr_i[AddrWidth-1:5], reg_addr_i[1:0]};
    assign w_idx    = reg_addr_i[4:2];
    assign w_err    = w_idx > 3'd4;
    assign w_we     = reg_valid_i & reg_write_i & ~w_err;
    always_comb begin
        w_wr = '0;
        for (int i = 0; i < 5; i++) w_wr[i] = w_we & (w_idx == 3'(i));
    end

    assign w_rsel = (w_idx == 3'd0) ? {16'b0, r_presc, 5'b0, r_os, r_ac, r_en} :
                    (w_idx == 3'd1) ? r_cnt :
                    (w_idx == 3'd2) ? r_cmp :
                    (w_idx == 3'd3) ? {30'b0, r_st} :
                    (w_idx == 3'd4) ? {30'b0, r_ie} : 32'b0;
    assign w_bmask = {{8{reg_wstrb_i[3]}}, {8{reg_wstrb_i[2]}}, {8{reg_wstrb_i[1]}}, {8{reg_wstrb_i[0]}}};
    assign w_wval  = (w_rsel & ~w_bmask) | (reg_wdata_i & w_bmask);

    assign reg_ready_o = reg_valid_i;
    assign reg_error_o = reg_valid_i & w_err;
    assign reg_rdata_o = (reg_valid_i & ~w_err) ? w_rsel : 32'b0;
    assign irq_o       = r_st & r_ie;

    // A software COUNT write suppresses the tick's compare/overflow evaluation entirely.
    assign w_tick   = r_en & (r_pcnt == r_presc);
    assign w_cnt_wr = w_wr[1] & |reg_wstrb_i;
    assign w_ev     = w_tick & ~w_cnt_wr;
    assign w_match  = r_cnt == r_cmp;
    assign w_max    = &r_cnt;
    assign w_set    = {w_ev & w_max & ~(w_match & r_ac), w_ev & w_match};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_en    <= 1'b0;
            r_ac    <= 1'b0;
            r_os    <= 1'b0;
            r_presc <= '0;
            r_pcnt  <= '0;
            r_cnt   <= '0;
            r_cmp   <= '1;
            r_st    <= '0;
            r_ie    <= '0;
        end else begin
            if (r_en) r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
            if (w_wr[0] & reg_wstrb_i[1]) begin
                r_pcnt  <= '0;
                r_presc <= w_wval[15:8];
            end
            if (w_wr[0] & reg_wstrb_i[0]) {r_os, r_ac, r_en} <= w_wval[2:0];
            else if (w_ev & w_match & r_os) r_en <= 1'b0;
            if (w_cnt_wr) r_cnt <= w_wval;
            else if (w_ev) r_cnt <= (w_match & r_ac) ? '0 : r_cnt + 1'b1;
            if (w_wr[2]) r_cmp <= w_wval;
            r_st <= (r_st & ~((w_wr[3] & reg_wstrb_i[0]) ? reg_wdata_i[1:0] : 2'b0)) | w_set;
            if (w_wr[4]) r_ie <= w_wval[1:0];
        end
    end
endmodule
